// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and walks instruction memory one word at a time
// through a req/ack handshake. Each fetched word is handed to decode on a
// valid/ready port. Branch and jump redirects from later stages retarget the PC
// and cancel or drain whatever fetch is in progress.
//
// Handshake semantics (both ports):
//   - A transfer happens on a rising clk edge where the valid-side signal
//     (imem_req / inst_valid) and the response-side signal (imem_ack /
//     inst_ready) are both 1.
//   - Once raised, a valid-side signal and its payload (imem_addr /
//     inst_data, inst_pc) stay unchanged until the transfer. The two
//     exceptions are reset, which drops everything, and a redirect, which may
//     squash inst_valid.
//   - The response side may be high in the same cycle the valid side rises.
//
// Ports:
//   clk             clock, all logic on posedge
//   reset           synchronous, active-low reset
//   enable          1 = keep fetching; 0 = stop once in-flight work completes
//   imem_req        memory request valid (registered)
//   imem_addr       word-aligned fetch address (registered)
//   imem_ack        memory response valid
//   imem_rdata      instruction word, valid with imem_ack
//   redirect_valid  single-cycle redirect pulse
//   redirect_pc     redirect target, low two bits ignored
//   inst_valid      fetched word valid for decode (registered)
//   inst_data       fetched word (registered)
//   inst_pc         address of inst_data (registered)
//   inst_ready      decode accepts the word
//   state_dbg       current FSM state, for observation only
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic              valid_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] ipc_n;

    // finish: current work is complete; pick the next state from enable.
    // launch_pc: address the next request goes to if enable is high.
    logic              finish;
    logic [ADDR_W-1:0] launch_pc;
    logic [ADDR_W-1:0] target;

    assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_n     = imem_req;
        addr_n    = imem_addr;
        valid_n   = inst_valid;
        data_n    = inst_data;
        ipc_n     = inst_pc;
        finish    = 1'b0;
        launch_pc = pc;

        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_n = target;
                end else if (enable) begin
                    state_n = S_REQ;
                    req_n   = 1'b1;
                    addr_n  = pc;
                end
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_n = target;
                    if (imem_ack) begin
                        // Response arrived for the wrong path: drop it.
                        finish    = 1'b1;
                        launch_pc = target;
                    end else begin
                        // Request must still complete before a new one.
                        state_n = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    valid_n = 1'b1;
                    data_n  = imem_rdata;
                    ipc_n   = pc;
                    pc_n    = pc + ADDR_W'(4);
                    req_n   = 1'b0;
                    state_n = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // Squash; if inst_ready was also high the word has been
                    // taken and the redirect source discards it downstream.
                    valid_n   = 1'b0;
                    pc_n      = target;
                    finish    = 1'b1;
                    launch_pc = target;
                end else if (inst_ready) begin
                    valid_n = 1'b0;
                    finish  = 1'b1;
                end
            end

            S_DRAIN: begin
                if (imem_ack) begin
                    // Wrong-path data is discarded. A redirect arriving with
                    // the ack still updates the PC used for the next fetch.
                    launch_pc = redirect_valid ? target : pc;
                    pc_n      = launch_pc;
                    finish    = 1'b1;
                end else if (redirect_valid) begin
                    pc_n = target;
                end
            end

            default: begin
                state_n = S_IDLE;
                req_n   = 1'b0;
            end
        endcase

        if (finish) begin
            if (enable) begin
                state_n = S_REQ;
                req_n   = 1'b1;
                addr_n  = launch_pc;
            end else begin
                state_n = S_IDLE;
                req_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= PC_INIT;
            imem_req   <= 1'b0;
            imem_addr  <= PC_INIT;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_req   <= req_n;
            imem_addr  <= addr_n;
            inst_valid <= valid_n;
            inst_data  <= data_n;
            inst_pc    <= ipc_n;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Bench for fetch_sequencer. dut0 uses RESET_PC=0 and carries the table,
// hand-written corner sequences and randomized traffic against a fetch-stream
// model. dut1 uses RESET_PC=0xFFFF_FFFC for PC wrap and reset-in-drain.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, imem_ack, redirect_valid, inst_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst_data, inst_pc;
    logic [1:0]  state_dbg;

    logic        b_reset, b_enable, b_imem_ack, b_redirect_valid, b_inst_ready;
    logic [31:0] b_imem_rdata, b_redirect_pc;
    logic        b_imem_req, b_inst_valid;
    logic [31:0] b_imem_addr, b_inst_data, b_inst_pc;
    logic [1:0]  b_state_dbg;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .state_dbg(state_dbg)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(b_reset), .enable(b_enable),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .inst_valid(b_inst_valid), .inst_data(b_inst_data), .inst_pc(b_inst_pc),
        .inst_ready(b_inst_ready), .state_dbg(b_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive dut0 inputs for one cycle; rdata follows the current address.
    task automatic drive0(input logic en, input logic ack, input logic rdy,
                          input logic redir, input logic [31:0] tgt);
        enable         = en;
        imem_ack       = ack;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rdata     = memf(imem_addr);
        tick();
    endtask

    task automatic drive1(input logic rst, input logic en, input logic ack,
                          input logic rdy, input logic redir, input logic [31:0] tgt);
        b_reset          = rst;
        b_enable         = en;
        b_imem_ack       = ack;
        b_inst_ready     = rdy;
        b_redirect_valid = redir;
        b_redirect_pc    = tgt;
        b_imem_rdata     = memf(b_imem_addr);
        tick();
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        en;
        logic        ack;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[10];

    // random-phase state
    logic [31:0] exp_pc;
    logic [31:0] hold_data, hold_pc;
    logic        mem_busy;
    int          mem_wait;
    logic        p_req, p_ack, p_valid, p_rdy, p_redir;
    logic [31:0] p_addr, p_tgt, p_ipc, p_idata;

    initial begin
        // Ack in the same cycle as req, decode always ready.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h4};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h8};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hC, 1'b1, 32'hC};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hC, 1'b0, 32'hC};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hC, 1'b0, 32'hC};

        reset = 1'b0; enable = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        b_reset = 1'b0; b_enable = 1'b0; b_imem_ack = 1'b0; b_imem_rdata = '0;
        b_redirect_valid = 1'b0; b_redirect_pc = '0; b_inst_ready = 1'b0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_addr",  imem_addr,           32'h0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data",  inst_data,           32'h0);
        chk("rst_pc",    inst_pc,             32'h0);
        reset = 1'b1;

        // ---- 1: table, back-to-back single-cycle memory ----
        for (int i = 0; i < 10; i++) begin
            drive0(tbl[i].en, tbl[i].ack, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", i),   {31'd0, imem_req},   {31'd0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_addr", i),  imem_addr,           tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_ipc", i),   inst_pc,             tbl[i].exp_pc);
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_data", i), inst_data, memf(tbl[i].exp_pc));
        end

        // ---- 2: ack three cycles after req ----
        drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("lat_req0",  {31'd0, imem_req}, 32'd1);
        chk("lat_addr0", imem_addr,         32'h10);
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("lat_req_hold",  {31'd0, imem_req},   32'd1);
            chk("lat_addr_hold", imem_addr,           32'h10);
            chk("lat_no_valid",  {31'd0, inst_valid}, 32'd0);
        end
        drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("lat_valid", {31'd0, inst_valid}, 32'd1);
        chk("lat_ipc",   inst_pc,             32'h10);
        chk("lat_data",  inst_data,           memf(32'h10));
        chk("lat_req_d", {31'd0, imem_req},   32'd0);

        // ---- 3: decode stalls five cycles ----
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_ipc",   inst_pc,             32'h10);
            chk("stall_data",  inst_data,           memf(32'h10));
            chk("stall_noreq", {31'd0, imem_req},   32'd0);
        end
        drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rel_valid", {31'd0, inst_valid}, 32'd0);
        chk("rel_req",   {31'd0, imem_req},   32'd1);
        chk("rel_addr",  imem_addr,           32'h14);

        // ---- 4: redirect during REQ, ack two cycles later ----
        drive0(1'b1, 1'b0, 1'b1, 1'b1, 32'h103);
        chk("drn_req",  {31'd0, imem_req}, 32'd1);
        chk("drn_addr", imem_addr,         32'h14);
        drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("drn_req2",   {31'd0, imem_req},   32'd1);
        chk("drn_addr2",  imem_addr,           32'h14);
        chk("drn_valid2", {31'd0, inst_valid}, 32'd0);
        drive0(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("drn_discard", {31'd0, inst_valid}, 32'd0);
        chk("drn_newreq",  {31'd0, imem_req},   32'd1);
        chk("drn_newaddr", imem_addr,           32'h100);
        drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("drn_valid", {31'd0, inst_valid}, 32'd1);
        chk("drn_ipc",   inst_pc,             32'h100);

        // ---- 5: redirect in HOLD with decode stalled ----
        drive0(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        chk("sq_valid", {31'd0, inst_valid}, 32'd0);
        chk("sq_req",   {31'd0, imem_req},   32'd1);
        chk("sq_addr",  imem_addr,           32'h200);
        drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("sq_valid2", {31'd0, inst_valid}, 32'd1);
        chk("sq_ipc",    inst_pc,             32'h200);
        drive0(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("sq_idle_req",   {31'd0, imem_req},   32'd0);
        chk("sq_idle_valid", {31'd0, inst_valid}, 32'd0);

        // ---- 6: PC wrap and reset in DRAIN (dut1) ----
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("w_rst_req",  {31'd0, b_imem_req}, 32'd0);
        chk("w_rst_addr", b_imem_addr,         32'hFFFF_FFFC);
        chk("w_rst_ipc",  b_inst_pc,           32'h0);
        drive1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("w_addr0", b_imem_addr, 32'hFFFF_FFFC);
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("w_ipc0",  b_inst_pc,   32'hFFFF_FFFC);
        chk("w_data0", b_inst_data, memf(32'hFFFF_FFFC));
        drive1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("w_req1",  {31'd0, b_imem_req}, 32'd1);
        chk("w_addr1", b_imem_addr,         32'h0);
        drive1(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
        chk("w_drn_req",  {31'd0, b_imem_req}, 32'd1);
        chk("w_drn_addr", b_imem_addr,         32'h0);
        drive1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("w_rstd_req",   {31'd0, b_imem_req},   32'd0);
        chk("w_rstd_addr",  b_imem_addr,           32'hFFFF_FFFC);
        chk("w_rstd_valid", {31'd0, b_inst_valid}, 32'd0);
        drive1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("w_post_req",  {31'd0, b_imem_req}, 32'd1);
        chk("w_post_addr", b_imem_addr,         32'hFFFF_FFFC);

        // ---- randomized traffic against the fetch-stream model ----
        // Model: decode must see consecutive words from exp_pc, restarting
        // at the (aligned) target after every redirect.
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        exp_pc   = 32'h0;
        mem_busy = 1'b0;
        mem_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            enable         = ($urandom_range(0, 7) != 0);
            inst_ready     = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_wait = $urandom_range(0, 3);
                end
                imem_ack = (mem_wait == 0);
            end else begin
                imem_ack = 1'b0;
            end
            imem_rdata = imem_ack ? memf(imem_addr) : $urandom;

            p_req = imem_req;   p_ack = imem_ack;   p_addr = imem_addr;
            p_valid = inst_valid; p_rdy = inst_ready; p_redir = redirect_valid;
            p_tgt = redirect_pc; p_ipc = inst_pc;  p_idata = inst_data;

            tick();

            if (imem_ack) mem_busy = 1'b0;
            else if (mem_busy) mem_wait--;

            if (p_valid && p_rdy && !p_redir) begin
                chk("rnd_ipc",  p_ipc,   exp_pc);
                chk("rnd_data", p_idata, memf(p_ipc));
                exp_pc = exp_pc + 32'd4;
            end
            if (p_redir) begin
                exp_pc = {p_tgt[31:2], 2'b00};
                chk("rnd_squash", {31'd0, inst_valid}, 32'd0);
            end
            if (p_req && !p_ack) begin
                chk("rnd_req_hold",  {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_hold", imem_addr,         p_addr);
            end
            if (p_valid && !p_rdy && !p_redir) begin
                hold_pc   = p_ipc;
                hold_data = p_idata;
                chk("rnd_vhold",  {31'd0, inst_valid}, 32'd1);
                chk("rnd_pchold", inst_pc,             hold_pc);
                chk("rnd_dhold",  inst_data,           hold_data);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
